keypad_scan: RTL

- Input-side counterpart of the 7-segment scan display: scans a 4x4 matrix keypad one column at a time, synchronises and debounces the row returns, and emits one key event per physical press.
- Decimal keys shift into a six-digit BCD entry register. The display scanner consumes this register as its six digit inputs.

---
 rtl/keypad_scan.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//   Scans a 4x4 active-low matrix keypad one column at a time, synchronises and
//   debounces the row returns frame by frame, and emits one key event per
//   physical press. Decimal keys shift into a six-digit BCD entry register that
//   feeds the 7-segment scan display; key 15 clears the entry.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   row[3:0]   in   row returns, active-low, externally pulled up
//   col[3:0]   out  column drive, active-low, one-cold (1110 after reset)
//   key[3:0]   out  code (4*row + col) of the last accepted key
//   key_valid  out  one-cycle pulse per accepted press
//   key_held   out  high while the accepted key stays pressed (debounced)
//   dig1..dig6 out  BCD entry digits, dig1 = most recent
// -----------------------------------------------------------------------------
module keypad_scan #(
    parameter int SCAN_DIV = 1000,  // clock cycles per column window (>= 2)
    parameter int DEBOUNCE = 4      // identical frames to accept press/release (>= 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] dig4,
    output logic [3:0] dig5,
    output logic [3:0] dig6
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    // Number of set bits in a 4-bit vector.
    function automatic logic [2:0] pop4(input logic [3:0] v);
        pop4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Index of the lowest set bit (caller guarantees at least one bit set).
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        if (v[0]) begin
            low_idx = 2'd0;
        end else if (v[1]) begin
            low_idx = 2'd1;
        end else if (v[2]) begin
            low_idx = 2'd2;
        end else begin
            low_idx = 2'd3;
        end
    endfunction

    // Synchroniser and scan state
    logic [3:0]       row_meta_q, row_sync_q;
    logic [1:0]       col_tag1_q, col_tag_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       acc_cnt_q, acc_cnt_d;
    logic [3:0]       acc_code_q, acc_code_d;

    // Frame classification
    logic       win_end_s, frame_end_s;
    logic [3:0] row_low_s;
    logic [2:0] win_pop_s, sum_s;
    logic [1:0] win_sat_s, tot_cnt_s;
    logic [3:0] tot_code_s;
    logic       frame_none_s, frame_single_s, frame_key_s;

    // Debounce FSM and outputs
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic [5:0][3:0]  dig_q, dig_d;
    logic             accept_s;
    logic [3:0]       accept_code_s;

    // Row synchroniser; the driven column index travels through an identical
    // two-stage pipe so every synchronised row vector is tagged with the
    // column that produced it (matters when SCAN_DIV is only 2 or 3).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            col_tag1_q <= 2'd0;
            col_tag_q  <= 2'd0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            col_tag1_q <= col_idx_q;
            col_tag_q  <= col_tag1_q;
        end
    end

    // Window/frame timing and running count of low rows within the frame.
    // The count saturates at 2: only "none", "exactly one" and "more" matter.
    always_comb begin
        win_end_s   = (div_q == DIV_W'(SCAN_DIV - 1));
        frame_end_s = win_end_s && (col_idx_q == 2'd3);
        row_low_s   = ~row_sync_q;
        win_pop_s   = pop4(row_low_s);
        win_sat_s   = (win_pop_s > 3'd2) ? 2'd2 : win_pop_s[1:0];
        sum_s       = {1'b0, acc_cnt_q} + {1'b0, win_sat_s};
        tot_cnt_s   = (sum_s > 3'd2) ? 2'd2 : sum_s[1:0];
        if ((acc_cnt_q == 2'd0) && (win_pop_s == 3'd1)) begin
            tot_code_s = {low_idx(row_low_s), col_tag_q};
        end else begin
            tot_code_s = acc_code_q;
        end
        frame_none_s   = frame_end_s && (tot_cnt_s == 2'd0);
        frame_single_s = frame_end_s && (tot_cnt_s == 2'd1);
        frame_key_s    = frame_end_s && (tot_cnt_s != 2'd0);
    end

    // Divider, column rotation and per-frame accumulator next state.
    always_comb begin
        div_d      = div_q;
        col_d      = col_q;
        col_idx_d  = col_idx_q;
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (win_end_s) begin
            div_d     = {DIV_W{1'b0}};
            col_d     = {col_q[2:0], col_q[3]};
            col_idx_d = col_idx_q + 2'd1;
            if (frame_end_s) begin
                acc_cnt_d  = 2'd0;
                acc_code_d = 4'd0;
            end else begin
                acc_cnt_d  = tot_cnt_s;
                acc_code_d = tot_code_s;
            end
        end else begin
            div_d = div_q + DIV_W'(1'b1);
        end
    end

    // Scan registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= {DIV_W{1'b0}};
            col_q      <= 4'b1110;
            col_idx_q  <= 2'd0;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
        end else begin
            div_q      <= div_d;
            col_q      <= col_d;
            col_idx_q  <= col_idx_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Debounce FSM next state, key event and digit entry.
    // MULTI frames count as "no key" while looking for a press and as
    // "key present" while the accepted key is held.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cand_d        = cand_q;
        key_d         = key_q;
        key_valid_d   = 1'b0;
        key_held_d    = key_held_q;
        dig_d         = dig_q;
        accept_s      = 1'b0;
        accept_code_s = cand_q;
        case (state_q)
            IDLE: begin
                if (frame_single_s) begin
                    cand_d = tot_code_s;
                    if (DEBOUNCE == 1) begin
                        accept_s      = 1'b1;
                        accept_code_s = tot_code_s;
                        state_d       = HELD;
                        cnt_d         = {CNT_W{1'b0}};
                    end else begin
                        state_d = PRESS_CHK;
                        cnt_d   = CNT_W'(1'b1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_CHK: begin
                if (frame_single_s) begin
                    if (tot_code_s == cand_q) begin
                        if ((cnt_q + CNT_W'(1'b1)) == CNT_W'(DEBOUNCE)) begin
                            accept_s      = 1'b1;
                            accept_code_s = cand_q;
                            state_d       = HELD;
                            cnt_d         = {CNT_W{1'b0}};
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1'b1);
                        end
                    end else begin
                        cand_d = tot_code_s;
                        cnt_d  = CNT_W'(1'b1);
                    end
                end else if (frame_end_s) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = PRESS_CHK;
                end
            end
            HELD: begin
                if (frame_none_s) begin
                    if (DEBOUNCE == 1) begin
                        state_d    = IDLE;
                        key_held_d = 1'b0;
                        cnt_d      = {CNT_W{1'b0}};
                    end else begin
                        state_d = RELEASE_CHK;
                        cnt_d   = CNT_W'(1'b1);
                    end
                end else begin
                    state_d = HELD;
                end
            end
            RELEASE_CHK: begin
                if (frame_none_s) begin
                    if ((cnt_q + CNT_W'(1'b1)) == CNT_W'(DEBOUNCE)) begin
                        state_d    = IDLE;
                        key_held_d = 1'b0;
                        cnt_d      = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end
                end else if (frame_key_s) begin
                    state_d = HELD;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = RELEASE_CHK;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        // Entry action into HELD: publish the key and update the digits.
        if (accept_s) begin
            key_d       = accept_code_s;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            if (accept_code_s <= 4'd9) begin
                dig_d = {dig_q[4:0], accept_code_s};
            end else if (accept_code_s == 4'd15) begin
                dig_d = 24'd0;
            end else begin
                dig_d = dig_q;
            end
        end else begin
            key_valid_d = 1'b0;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            cand_q      <= 4'd0;
            key_q       <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            dig_q       <= 24'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            dig_q       <= dig_d;
        end
    end

    assign col       = col_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign dig1      = dig_q[0];
    assign dig2      = dig_q[1];
    assign dig3      = dig_q[2];
    assign dig4      = dig_q[3];
    assign dig5      = dig_q[4];
    assign dig6      = dig_q[5];

endmodule
